// File: rtl/rabbit_pkg.sv
// Shared constants and types for the Rabbit counter-system stages
// (forward update and rewind).
package rabbit_pkg;

  localparam int unsigned LIMB_W    = 32;
  localparam int unsigned N_LIMBS   = 8;
  localparam int unsigned MAX_STEPS = 16;

  // Counter increment constants; entry j is added to limb C_j.
  localparam logic [LIMB_W-1:0] A_CONST [N_LIMBS] = '{
    32'h4D34D34D, 32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D,
    32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D, 32'hD34D34D3
  };

  typedef enum logic [1:0] {
    RW_IDLE,
    RW_SUB,
    RW_FIN
  } rw_state_e;

endpackage

// File: rtl/rabbit_limb_sub.sv
// Combinational single-limb subtractor with borrow-in and borrow-out.
module rabbit_limb_sub
  import rabbit_pkg::*;
(
  input  logic [LIMB_W-1:0] a_i,
  input  logic [LIMB_W-1:0] b_i,
  input  logic              bin_i,
  output logic [LIMB_W-1:0] d_o,
  output logic              bout_o
);

  logic [LIMB_W:0] diff;

  // One extra bit catches the borrow out of the limb.
  always_comb begin
    diff   = {1'b0, a_i} - {1'b0, b_i} - {{LIMB_W{1'b0}}, bin_i};
    d_o    = diff[LIMB_W-1:0];
    bout_o = diff[LIMB_W];
  end

endmodule

// File: rtl/rabbit_counter_rewind.sv
// Rewinds the Rabbit counter system by 1..MAX_STEPS forward iterations,
// one 32-bit limb per cycle, checking each step's final borrow against
// the supplied carry history.
module rabbit_counter_rewind
  import rabbit_pkg::*;
#(
  parameter int unsigned MAX_STEPS = rabbit_pkg::MAX_STEPS
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [4:0]                  steps,
  input  logic [LIMB_W*N_LIMBS-1:0]   counter_in,
  input  logic                        carry_in,
  input  logic [MAX_STEPS-1:0]        carry_hist,
  output logic                        busy,
  output logic                        done,
  output logic [LIMB_W*N_LIMBS-1:0]   counter_out,
  output logic                        carry_out,
  output logic                        err
);

  localparam int unsigned STATE_W = LIMB_W * N_LIMBS;
  localparam int unsigned KW      = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [4:0]  STEP_MAX = 5'(MAX_STEPS);
  localparam logic [2:0]  LAST_J   = 3'(N_LIMBS - 1);

  rw_state_e              state_q, state_d;
  logic [2:0]             j_q, j_d;
  logic [4:0]             k_q, k_d;
  logic [4:0]             steps_q, steps_d;
  logic [MAX_STEPS-1:0]   hist_q, hist_d;
  logic                   carry_q, carry_d;
  logic [STATE_W-1:0]     work_q, work_d;
  logic                   borrow_q, borrow_d;
  logic                   err_q, err_d;
  logic [STATE_W-1:0]     cnt_out_q, cnt_out_d;
  logic                   cout_q, cout_d;

  logic [4:0]             steps_clamped;
  logic [4:0]             k_m1, s_m1;
  logic                   bin;
  logic [LIMB_W-1:0]      limb_d;
  logic                   limb_bout;
  logic                   exp_carry;
  logic [STATE_W-1:0]     work_rot;

  // Head limb of the rotating work register goes through the subtractor;
  // the first limb of each step takes its borrow from the carry history.
  always_comb begin
    k_m1 = k_q - 5'd1;
    s_m1 = steps_q - 5'd1;
    bin  = (j_q == 3'd0) ? hist_q[k_q[KW-1:0]] : borrow_q;
  end

  rabbit_limb_sub u_sub (
    .a_i    (work_q[LIMB_W-1:0]),
    .b_i    (A_CONST[j_q]),
    .bin_i  (bin),
    .d_o    (limb_d),
    .bout_o (limb_bout)
  );

  // Next-state logic: accept, limb/step sequencing, carry check, result capture.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    k_d       = k_q;
    steps_d   = steps_q;
    hist_d    = hist_q;
    carry_d   = carry_q;
    work_d    = work_q;
    borrow_d  = borrow_q;
    err_d     = err_q;
    cnt_out_d = cnt_out_q;
    cout_d    = cout_q;

    steps_clamped = (steps > STEP_MAX) ? STEP_MAX : steps;
    work_rot      = {limb_d, work_q[STATE_W-1:LIMB_W]};
    exp_carry     = (k_q == 5'd0) ? carry_q : hist_q[k_m1[KW-1:0]];

    unique case (state_q)
      RW_IDLE: begin
        if (start) begin
          steps_d = steps_clamped;
          hist_d  = carry_hist;
          carry_d = carry_in;
          work_d  = counter_in;
          err_d   = 1'b0;
          j_d     = 3'd0;
          k_d     = 5'd0;
          if (steps_clamped == 5'd0) begin
            cnt_out_d = counter_in;
            cout_d    = carry_in;
            state_d   = RW_FIN;
          end else begin
            state_d   = RW_SUB;
          end
        end
      end
      RW_SUB: begin
        // After N_LIMBS rotations the register is back in limb order.
        work_d   = work_rot;
        borrow_d = limb_bout;
        j_d      = j_q + 3'd1;
        if (j_q == LAST_J) begin
          if (limb_bout != exp_carry) err_d = 1'b1;
          if (k_q == s_m1) begin
            cnt_out_d = work_rot;
            cout_d    = hist_q[s_m1[KW-1:0]];
            state_d   = RW_FIN;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      RW_FIN: begin
        state_d = RW_IDLE;
      end
      default: state_d = RW_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RW_IDLE;
      j_q       <= '0;
      k_q       <= '0;
      steps_q   <= '0;
      hist_q    <= '0;
      carry_q   <= 1'b0;
      work_q    <= '0;
      borrow_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      k_q       <= k_d;
      steps_q   <= steps_d;
      hist_q    <= hist_d;
      carry_q   <= carry_d;
      work_q    <= work_d;
      borrow_q  <= borrow_d;
      err_q     <= err_d;
      cnt_out_q <= cnt_out_d;
      cout_q    <= cout_d;
    end
  end

  // Handshake decoded from state; results driven from held registers.
  always_comb begin
    busy        = (state_q == RW_SUB);
    done        = (state_q == RW_FIN);
    counter_out = cnt_out_q;
    carry_out   = cout_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_rabbit_counter_rewind.sv
// Directed self-checking bench for rabbit_counter_rewind.
module tb_rabbit_counter_rewind;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   steps;
  logic [255:0] counter_in;
  logic         carry_in;
  logic [15:0]  carry_hist;
  logic         busy;
  logic         done;
  logic [255:0] counter_out;
  logic         carry_out;
  logic         err;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] AC = {
    32'hD34D34D3, 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3,
    32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3, 32'h4D34D34D
  };

  rabbit_counter_rewind #(.MAX_STEPS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .steps       (steps),
    .counter_in  (counter_in),
    .carry_in    (carry_in),
    .carry_hist  (carry_hist),
    .busy        (busy),
    .done        (done),
    .counter_out (counter_out),
    .carry_out   (carry_out),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; lat = cycles from accept to done (-1 on timeout).
  // Inputs are scrambled after accept to confirm they are latched.
  task automatic run_req(input logic [4:0] n, input logic [255:0] cv, input logic ci,
                         input logic [15:0] h, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    steps = n; counter_in = cv; carry_in = ci; carry_hist = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; counter_in = ~cv; carry_in = ~ci; carry_hist = ~h; steps = 5'd7;
    lat = -1; busy_cnt = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  // Forward-update a random state n times, then rewind and expect the origin.
  task automatic golden(input int n, input logic [4:0] sv);
    logic [255:0] s0, s;
    logic [256:0] sum;
    logic         c0, c;
    logic [15:0]  h;
    int lat, bc;
    for (int w = 0; w < 8; w++) s0[w*32 +: 32] = $urandom;
    c0 = 1'($urandom);
    h  = 16'($urandom);
    s = s0; c = c0;
    for (int i = 0; i < n; i++) begin
      h[n-1-i] = c;
      sum = {1'b0, s} + {1'b0, AC} + {256'd0, c};
      s = sum[255:0];
      c = sum[256];
    end
    run_req(sv, s, c, h, lat, bc);
    chk($sformatf("gold%0d_cnt", n), counter_out, s0);
    chk($sformatf("gold%0d_carry", n), {255'd0, carry_out}, {255'd0, c0});
    chk($sformatf("gold%0d_err", n), {255'd0, err}, 256'd0);
    chk($sformatf("gold%0d_lat", n), 256'(lat), 256'(8*n+1));
    chk($sformatf("gold%0d_busy", n), 256'(bc), 256'(8*n));
  endtask

  initial begin
    int lat, bc, dones;
    logic [255:0] neg;
    rst = 1'b1; start = 1'b0; steps = '0; counter_in = '0; carry_in = 1'b0; carry_hist = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt",   counter_out, 256'd0);
    chk("rst_carry", {255'd0, carry_out}, 256'd0);
    chk("rst_busy",  {255'd0, busy}, 256'd0);
    chk("rst_done",  {255'd0, done}, 256'd0);
    chk("rst_err",   {255'd0, err}, 256'd0);
    rst = 1'b0;

    // Zero round trip
    run_req(5'd1, AC, 1'b0, 16'h0000, lat, bc);
    chk("zero_cnt",   counter_out, 256'd0);
    chk("zero_carry", {255'd0, carry_out}, 256'd0);
    chk("zero_err",   {255'd0, err}, 256'd0);
    chk("zero_lat",   256'(lat), 256'd9);

    // Borrow path: 0 - A wraps to 2^256 - A
    neg = 256'd0 - AC;
    run_req(5'd1, 256'd0, 1'b1, 16'h0000, lat, bc);
    chk("borrow_cnt", counter_out, neg);
    chk("borrow_c0",  {224'd0, counter_out[31:0]},  {224'd0, 32'hB2CB2CB3});
    chk("borrow_c1",  {224'd0, counter_out[63:32]}, {224'd0, 32'h2CB2CB2C});
    chk("borrow_err", {255'd0, err}, 256'd0);

    // Carry mismatch: rewind still completes, err flagged
    run_req(5'd1, AC, 1'b1, 16'h0000, lat, bc);
    chk("mis_cnt", counter_out, 256'd0);
    chk("mis_err", {255'd0, err}, 256'd1);

    // steps = 0 passthrough, err cleared by accept
    run_req(5'd0, {8{32'h12345678}}, 1'b1, 16'hFFFF, lat, bc);
    chk("s0_cnt",   counter_out, {8{32'h12345678}});
    chk("s0_carry", {255'd0, carry_out}, 256'd1);
    chk("s0_err",   {255'd0, err}, 256'd0);
    chk("s0_lat",   256'(lat), 256'd1);
    chk("s0_busy",  256'(bc), 256'd0);

    // Golden model for every step count, then clamp of an oversized request
    for (int n = 1; n <= 16; n++) golden(n, 5'(n));
    golden(16, 5'd31);

    // start held high while busy and through done: exactly one done
    @(posedge clk); #1;
    steps = 5'd2; counter_in = AC; carry_in = 1'b0; carry_hist = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    lat = -1; dones = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      if (cyc == 18) start = 1'b0;
      if (cyc > 18 && busy) dones += 100;
      @(posedge clk); #1;
    end
    chk("hold_lat",   256'(lat), 256'd17);
    chk("hold_dones", 256'(dones), 256'd1);

    // Reset in the middle of a steps=4 request
    @(posedge clk); #1;
    steps = 5'd4; counter_in = {8{32'hA5A5A5A5}}; carry_in = 1'b0; carry_hist = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cnt",   counter_out, 256'd0);
    chk("mrst_carry", {255'd0, carry_out}, 256'd0);
    chk("mrst_busy",  {255'd0, busy}, 256'd0);
    chk("mrst_done",  {255'd0, done}, 256'd0);
    chk("mrst_err",   {255'd0, err}, 256'd0);

    // Normal request after the abort
    neg = 256'd0 - AC;
    run_req(5'd1, 256'd0, 1'b1, 16'h0000, lat, bc);
    chk("post_cnt", counter_out, neg);
    chk("post_err", {255'd0, err}, 256'd0);
    chk("post_lat", 256'(lat), 256'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
